// File: rtl/dma_periph_fifo_responder.sv
// Peripheral-side DMA responder: Avalon-MM slave fronting an RX and a TX FIFO, plus a request/acknowledge FSM.
// Latency: DATA/STATUS read data returns 1 cycle after acceptance; request_o rises 1 cycle after its condition.
// Backpressure: waitrequest on DATA reads while RX is empty and on DATA writes while TX is full; rx_ready_o = RX not full.
module dma_periph_fifo_responder #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              request_o,
  input  logic              acknowledge_i,
  input  logic              amm_address_i,
  input  logic              amm_read_i,
  input  logic              amm_write_i,
  input  logic [DATA_W-1:0] amm_writedata_i,
  output logic              amm_waitrequest_o,
  output logic [DATA_W-1:0] amm_readdata_o,
  output logic              amm_readdatavalid_o,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] ONE_LVL   = LVL_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [PTR_W-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [LVL_W-1:0]  rx_level_q, rx_level_d;
  logic [LVL_W-1:0]  tx_level_q, tx_level_d;
  logic [LVL_W-1:0]  tx_free;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;

  // ---------------------------------------------------------------------------
  // Avalon command decode
  // ---------------------------------------------------------------------------
  logic waitreq;
  logic rd_acc, wr_acc;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              readdatavalid_q, readdatavalid_d;

  // ---------------------------------------------------------------------------
  // Request FSM state
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] cnt_inc;
  logic             rx_burst_ok, tx_burst_ok, burst_evt;

  assign rx_empty = (rx_level_q == '0);
  assign rx_full  = (rx_level_q == DEPTH_LVL);
  assign tx_empty = (tx_level_q == '0);
  assign tx_full  = (tx_level_q == DEPTH_LVL);
  assign tx_free  = DEPTH_LVL - tx_level_q;

  // Stall only DATA accesses that cannot complete; a read takes priority over a simultaneous write.
  always_comb begin
    waitreq = 1'b0;
    if (amm_read_i) begin
      waitreq = ~amm_address_i & rx_empty;
    end else if (amm_write_i) begin
      waitreq = ~amm_address_i & tx_full;
    end
  end

  assign rd_acc  = amm_read_i & ~waitreq;
  assign wr_acc  = amm_write_i & ~amm_read_i & ~waitreq;
  assign rx_pop  = rd_acc & ~amm_address_i;
  assign tx_push = wr_acc & ~amm_address_i;
  assign rx_push = rx_valid_i & ~rx_full;
  assign tx_pop  = ~tx_empty & tx_ready_i;

  assign status_word = {{(DATA_W - 2*LVL_W){1'b0}}, tx_free, rx_level_q};

  // RX FIFO pointer and level next-state; simultaneous push and pop leaves the level alone.
  always_comb begin
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_level_d = rx_level_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + ONE_PTR;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + ONE_PTR;
    case ({rx_push, rx_pop})
      2'b10:   rx_level_d = rx_level_q + ONE_LVL;
      2'b01:   rx_level_d = rx_level_q - ONE_LVL;
      default: rx_level_d = rx_level_q;
    endcase
  end

  // TX FIFO pointer and level next-state; simultaneous push and pop leaves the level alone.
  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + ONE_PTR;
    if (tx_pop)  tx_rptr_d = tx_rptr_q + ONE_PTR;
    case ({tx_push, tx_pop})
      2'b10:   tx_level_d = tx_level_q + ONE_LVL;
      2'b01:   tx_level_d = tx_level_q - ONE_LVL;
      default: tx_level_d = tx_level_q;
    endcase
  end

  // FIFO storage writes; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_i;
    if (tx_push) tx_mem_q[tx_wptr_q] <= amm_writedata_i;
  end

  // FIFO pointer and level registers; reset discards any buffered words.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
    end else begin
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_level_q <= tx_level_d;
    end
  end

  // Read response: data (or a status snapshot) captured at acceptance, presented one cycle later.
  always_comb begin
    readdata_d      = readdata_q;
    readdatavalid_d = rd_acc;
    if (rd_acc) begin
      readdata_d = amm_address_i ? status_word : rx_mem_q[rx_rptr_q];
    end
  end

  // Read response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign rx_burst_ok = (rx_level_q >= BURST_LVL);
  assign tx_burst_ok = (tx_free >= BURST_LVL);
  assign burst_evt   = (dir_q == DIR_TX) ? tx_push : rx_pop;
  assign cnt_inc     = cnt_q + ONE_LVL;

  // Request FSM next-state: RX has priority when both directions can take a full burst.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (~acknowledge_i && (rx_burst_ok || tx_burst_ok)) begin
          state_d = S_REQ;
          dir_d   = rx_burst_ok ? DIR_RX : DIR_TX;
        end
      end
      S_REQ: begin
        if (acknowledge_i) begin
          state_d = S_GRANT;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (burst_evt) begin
          cnt_d = cnt_inc;
          if (cnt_inc == BURST_LVL) state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (~acknowledge_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request FSM registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_RX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign request_o           = (state_q == S_REQ) || (state_q == S_GRANT);
  assign amm_waitrequest_o   = waitreq;
  assign amm_readdata_o      = readdata_q;
  assign amm_readdatavalid_o = readdatavalid_q;
  assign rx_ready_o          = ~rx_full;
  assign tx_data_o           = tx_mem_q[tx_rptr_q];
  assign tx_valid_o          = ~tx_empty;

endmodule

// File: tb/tb_dma_periph_fifo_responder.sv
// Testbench for dma_periph_fifo_responder: table-driven RX burst/priority/status checks,
// then hand-written sequences for TX burst, stalls, pointer wrap and mid-burst reset.
module tb_dma_periph_fifo_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        request_o;
  logic        acknowledge_i;
  logic        amm_address_i;
  logic        amm_read_i;
  logic        amm_write_i;
  logic [63:0] amm_writedata_i;
  logic        amm_waitrequest_o;
  logic [63:0] amm_readdata_o;
  logic        amm_readdatavalid_o;
  logic [63:0] rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [63:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  int n_tests = 0;
  int n_fail  = 0;

  dma_periph_fifo_responder #(.DATA_W(64), .FIFO_DEPTH(16), .BURST_LEN(4)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .request_o           (request_o),
    .acknowledge_i       (acknowledge_i),
    .amm_address_i       (amm_address_i),
    .amm_read_i          (amm_read_i),
    .amm_write_i         (amm_write_i),
    .amm_writedata_i     (amm_writedata_i),
    .amm_waitrequest_o   (amm_waitrequest_o),
    .amm_readdata_o      (amm_readdata_o),
    .amm_readdatavalid_o (amm_readdatavalid_o),
    .rx_data_i           (rx_data_i),
    .rx_valid_i          (rx_valid_i),
    .rx_ready_o          (rx_ready_o),
    .tx_data_o           (tx_data_o),
    .tx_valid_o          (tx_valid_o),
    .tx_ready_i          (tx_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, ack, addr, rd, wr;
    logic [63:0] wdata, rxd;
    logic        rxv, txr;
    logic        e_req, e_wreq, e_rdv;
    logic [63:0] e_rdata;
    logic        e_rxr, e_txv;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic ack, input logic addr, input logic rd, input logic wr,
                              input logic [63:0] wdata, input logic [63:0] rxd, input logic rxv,
                              input logic e_req, input logic e_wreq, input logic e_rdv,
                              input logic [63:0] e_rdata);
    vec_t v;
    v.rst = 1'b0; v.ack = ack; v.addr = addr; v.rd = rd; v.wr = wr;
    v.wdata = wdata; v.rxd = rxd; v.rxv = rxv; v.txr = 1'b0;
    v.e_req = e_req; v.e_wreq = e_wreq; v.e_rdv = e_rdv; v.e_rdata = e_rdata;
    v.e_rxr = 1'b1; v.e_txv = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_bus();
    amm_address_i = 1'b0; amm_read_i = 1'b0; amm_write_i = 1'b0; amm_writedata_i = '0;
    rx_valid_i = 1'b0; rx_data_i = '0; tx_ready_i = 1'b0;
  endtask

  initial begin
    // ack held high keeps the FSM in IDLE while the RX FIFO is being filled.
    rst_i = 1'b1; acknowledge_i = 1'b1;
    idle_bus();
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("reset request_o", request_o, 1'b0);
    chk("reset readdatavalid", amm_readdatavalid_o, 1'b0);
    chk("reset readdata", amm_readdata_o, 64'h0);
    chk("reset rx_ready_o", rx_ready_o, 1'b1);
    chk("reset tx_valid_o", tx_valid_o, 1'b0);
    chk("reset waitrequest", amm_waitrequest_o, 1'b0);
    tick();

    // ack addr rd wr wdata rxd rxv | req wreq rdv rdata
    tbl[0]  = mk(1, 0, 0, 0, 64'h0,    64'hA0, 1, 0, 0, 0, 64'h0);
    tbl[1]  = mk(1, 0, 0, 0, 64'h0,    64'hA1, 1, 0, 0, 0, 64'h0);
    tbl[2]  = mk(1, 0, 0, 0, 64'h0,    64'hA2, 1, 0, 0, 0, 64'h0);
    tbl[3]  = mk(1, 0, 0, 0, 64'h0,    64'hA3, 1, 0, 0, 0, 64'h0);
    tbl[4]  = mk(0, 1, 1, 0, 64'h0,    64'h0,  0, 0, 0, 0, 64'h0);   // STATUS read, RX+TX both eligible
    tbl[5]  = mk(0, 0, 0, 0, 64'h0,    64'h0,  0, 1, 0, 1, 64'h204); // tx_free=16, rx_level=4
    tbl[6]  = mk(1, 0, 0, 0, 64'h0,    64'h0,  0, 1, 0, 0, 64'h0);
    tbl[7]  = mk(1, 0, 1, 0, 64'h0,    64'h0,  0, 1, 0, 0, 64'h0);
    tbl[8]  = mk(1, 0, 1, 0, 64'h0,    64'h0,  0, 1, 0, 1, 64'hA0);
    tbl[9]  = mk(1, 0, 1, 0, 64'h0,    64'h0,  0, 1, 0, 1, 64'hA1);
    tbl[10] = mk(1, 0, 1, 1, 64'hDEAD, 64'h0,  0, 1, 0, 1, 64'hA2);  // read+write: read wins
    tbl[11] = mk(1, 0, 0, 0, 64'h0,    64'h0,  0, 0, 0, 1, 64'hA3);  // burst done -> RELEASE
    tbl[12] = mk(1, 0, 1, 0, 64'h0,    64'h0,  0, 0, 1, 0, 64'h0);   // RX empty stalls
    tbl[13] = mk(1, 0, 0, 0, 64'h0,    64'h0,  0, 0, 0, 0, 64'h0);   // no re-request while ack high
    tbl[14] = mk(0, 0, 0, 0, 64'h0,    64'h0,  0, 0, 0, 0, 64'h0);
    tbl[15] = mk(0, 0, 0, 0, 64'h0,    64'h0,  0, 0, 0, 0, 64'h0);
    tbl[16] = mk(0, 0, 0, 0, 64'h0,    64'h0,  0, 1, 0, 0, 64'h0);   // TX request raised

    for (int i = 0; i < 17; i++) begin
      rst_i = tbl[i].rst; acknowledge_i = tbl[i].ack;
      amm_address_i = tbl[i].addr; amm_read_i = tbl[i].rd; amm_write_i = tbl[i].wr;
      amm_writedata_i = tbl[i].wdata; rx_data_i = tbl[i].rxd; rx_valid_i = tbl[i].rxv;
      tx_ready_i = tbl[i].txr;
      #1;
      chk($sformatf("vec%0d request_o", i), request_o, tbl[i].e_req);
      chk($sformatf("vec%0d waitrequest", i), amm_waitrequest_o, tbl[i].e_wreq);
      chk($sformatf("vec%0d readdatavalid", i), amm_readdatavalid_o, tbl[i].e_rdv);
      if (tbl[i].e_rdv) chk($sformatf("vec%0d readdata", i), amm_readdata_o, tbl[i].e_rdata);
      chk($sformatf("vec%0d rx_ready_o", i), rx_ready_o, tbl[i].e_rxr);
      chk($sformatf("vec%0d tx_valid_o", i), tx_valid_o, tbl[i].e_txv);
      tick();
    end
    idle_bus();

    // TX burst: grant, four writes, then drain in order.
    acknowledge_i = 1'b1;
    tick();
    chk("tx grant request_o", request_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      amm_write_i = 1'b1; amm_writedata_i = 64'hB0 + 64'(i);
      #1;
      chk($sformatf("tx write%0d waitrequest", i), amm_waitrequest_o, 1'b0);
      tick();
      chk($sformatf("tx write%0d head", i), tx_data_o, 64'hB0);
    end
    amm_write_i = 1'b0;
    #1;
    chk("tx burst done request_o", request_o, 1'b0);
    chk("tx valid after burst", tx_valid_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tx_ready_i = 1'b1;
      #1;
      chk($sformatf("tx drain%0d data", i), tx_data_o, 64'hB0 + 64'(i));
      tick();
    end
    tx_ready_i = 1'b0;
    #1;
    chk("tx drained valid", tx_valid_o, 1'b0);
    chk("release holds request low", request_o, 1'b0);

    // Read stall on empty RX until a word arrives.
    amm_address_i = 1'b0; amm_read_i = 1'b1;
    #1;
    chk("rd empty stall", amm_waitrequest_o, 1'b1);
    tick();
    chk("rd empty stall 2", amm_waitrequest_o, 1'b1);
    rx_valid_i = 1'b1; rx_data_i = 64'hC5;
    #1;
    chk("rd stall during push", amm_waitrequest_o, 1'b1);
    tick();
    rx_valid_i = 1'b0;
    #1;
    chk("rd accept after push", amm_waitrequest_o, 1'b0);
    tick();
    amm_read_i = 1'b0;
    #1;
    chk("rd stalled word valid", amm_readdatavalid_o, 1'b1);
    chk("rd stalled word data", amm_readdata_o, 64'hC5);

    // Fill TX to depth, then the 17th write stalls until one word is popped.
    for (int i = 0; i < 16; i++) begin
      amm_write_i = 1'b1; amm_writedata_i = 64'hD00 + 64'(i);
      #1;
      if (amm_waitrequest_o !== 1'b0) chk($sformatf("tx fill%0d waitrequest", i), amm_waitrequest_o, 1'b0);
      tick();
    end
    amm_writedata_i = 64'hD10;
    #1;
    chk("tx full stall", amm_waitrequest_o, 1'b1);
    tick();
    chk("tx full stall 2", amm_waitrequest_o, 1'b1);
    tx_ready_i = 1'b1;
    #1;
    chk("tx full stall during pop", amm_waitrequest_o, 1'b1);
    tick();
    tx_ready_i = 1'b0;
    #1;
    chk("tx write after pop", amm_waitrequest_o, 1'b0);
    tick();
    amm_write_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tx_ready_i = 1'b1;
      #1;
      chk($sformatf("tx full drain%0d", i), tx_data_o, 64'hD00 + 64'(i));
      tick();
    end
    tx_ready_i = 1'b0;
    #1;
    chk("tx full drained", tx_valid_o, 1'b0);

    // 40 words through RX with push and pop every cycle; pointers wrap, level stays at 1.
    rx_valid_i = 1'b1; rx_data_i = 64'hE00;
    tick();
    for (int i = 1; i < 40; i++) begin
      rx_data_i = 64'hE00 + 64'(i); amm_address_i = 1'b0; amm_read_i = 1'b1;
      #1;
      chk($sformatf("wrap%0d waitrequest", i), amm_waitrequest_o, 1'b0);
      tick();
      chk($sformatf("wrap%0d data", i), amm_readdata_o, 64'hE00 + 64'(i - 1));
    end
    rx_valid_i = 1'b0; amm_address_i = 1'b1;
    tick();
    amm_read_i = 1'b0;
    #1;
    chk("wrap status level", amm_readdata_o, 64'h201);
    amm_address_i = 1'b0; amm_read_i = 1'b1;
    tick();
    amm_read_i = 1'b0;
    #1;
    chk("wrap last word", amm_readdata_o, 64'hE27);

    // Mid-GRANT reset with 5 RX words buffered.
    for (int i = 0; i < 5; i++) begin
      rx_valid_i = 1'b1; rx_data_i = 64'hF0 + 64'(i);
      tick();
    end
    rx_valid_i = 1'b0;
    acknowledge_i = 1'b0;
    tick(); tick();
    chk("t1 rx request", request_o, 1'b1);
    acknowledge_i = 1'b1;
    tick();
    chk("t1 grant request", request_o, 1'b1);
    rst_i = 1'b1;
    tick();
    chk("t1 reset request_o", request_o, 1'b0);
    chk("t1 reset rx_ready_o", rx_ready_o, 1'b1);
    chk("t1 reset tx_valid_o", tx_valid_o, 1'b0);
    chk("t1 reset readdata", amm_readdata_o, 64'h0);
    tick();
    rst_i = 1'b0;
    amm_address_i = 1'b1; amm_read_i = 1'b1;
    #1;
    chk("t1 status no stall", amm_waitrequest_o, 1'b0);
    tick();
    amm_read_i = 1'b0;
    #1;
    chk("t1 status after reset", amm_readdata_o, 64'h200);
    chk("t1 request held low", request_o, 1'b0);
    amm_address_i = 1'b0; amm_read_i = 1'b1;
    #1;
    chk("t1 rx empty after reset", amm_waitrequest_o, 1'b1);
    idle_bus();
    acknowledge_i = 1'b0;
    tick(); tick();
    chk("t1 tx request after reset", request_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
